// File: rtl/ostc_pkg.sv
// ostc_pkg: FSM encoding, control-register address and bit positions for the turbo controller
package ostc_pkg;
  typedef enum logic [1:0] {SLOW, ARM_FAST, FAST, ARM_SLOW} ostc_state_e;
  localparam logic [15:0] CTRL_ADDR_DEF = 16'hFCF0;
  localparam int TURBO_EN = 0;
  localparam int LOCK = 1;
  localparam int ST_TURBO = 7;
  localparam int ST_ARM = 6;
endpackage

// File: rtl/ostc_debounce.sv
// ostc_debounce: accepts a new switch level only after 2^DEBOUNCE_BITS steady clocks
module ostc_debounce #(
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  logic [DEBOUNCE_BITS-1:0] cnt;
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      level <= 1'b0;
    end else if (raw == level) begin
      cnt <= '0;
    end else if (&cnt) begin
      cnt <= '0;
      level <= raw;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ostc_turbo_ctrl.sv
// ostc_turbo_ctrl: fast-SRAM window and ULA override with access-safe mode switching.
// Control register at CTRL_ADDR is present only when OSTC_CTRL_REG_EN is defined.
module ostc_turbo_ctrl
  import ostc_pkg::*;
#(
  parameter int FAST_PAGES = 3,
  parameter int DEBOUNCE_BITS = 4,
  parameter logic [15:0] CTRL_ADDR = CTRL_ADDR_DEF
) (
  input  logic        cpu_clk_in,
  input  logic        cpu_rst_n,
  input  logic [15:0] cpu_address,
  input  logic        cpu_rw,
  input  logic        turbo_switch,
  output logic        ula_a14,
  output logic        ula_a15,
  output logic        ula_rw,
  output logic [2:0]  sram_a,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ce_n,
  inout  wire  [7:0]  cpu_data,
  inout  wire  [7:0]  ula_data,
  output logic        turbo_active
);
`ifdef OSTC_CTRL_REG_EN
  localparam logic CTRL_EN = 1'b1;
`else
  localparam logic CTRL_EN = 1'b0;
`endif
  localparam logic [4:0] FAST_LIM = 5'(FAST_PAGES);
  ostc_state_e state, state_nx;
  logic [1:0] ctrl;
  logic [7:0] status;
  logic deb, want_fast, fast_hit, ctrl_hit, ctrl_rd, ovr;
  ostc_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_deb (
    .clk(cpu_clk_in),
    .rst_n(cpu_rst_n),
    .raw(turbo_switch),
    .level(deb)
  );
  assign fast_hit = {1'b0, cpu_address[15:12]} < FAST_LIM;
  assign ctrl_hit = CTRL_EN && cpu_address == CTRL_ADDR;
  assign ctrl_rd = ctrl_hit & cpu_rw;
  assign want_fast = ctrl[LOCK] ? ctrl[TURBO_EN] : deb;
  always_ff @(negedge cpu_clk_in) begin
    if (!cpu_rst_n) begin
      state <= SLOW;
      ctrl <= 2'b00;
    end else begin
      state <= state_nx;
      if (ctrl_hit && !cpu_rw) ctrl <= cpu_data[1:0];
    end
  end
  // Arming states wait for an access outside the fast window before switching mode
  always_comb begin
    state_nx = state;
    case (state)
      SLOW:     state_nx = want_fast ? ARM_FAST : SLOW;
      ARM_FAST: state_nx = !want_fast ? SLOW : !fast_hit ? FAST : ARM_FAST;
      FAST:     state_nx = want_fast ? FAST : ARM_SLOW;
      ARM_SLOW: state_nx = want_fast ? FAST : !fast_hit ? SLOW : ARM_SLOW;
      default:  state_nx = SLOW;
    endcase
  end
  always_comb begin
    status = '0;
    status[ST_TURBO] = turbo_active;
    status[ST_ARM] = state == ARM_FAST || state == ARM_SLOW;
    status[1:0] = ctrl;
  end
  assign turbo_active = cpu_rst_n && (state == FAST || state == ARM_SLOW);
  assign ovr = fast_hit & turbo_active;
  assign ula_a14 = ovr | cpu_address[14];
  assign ula_a15 = ovr | cpu_address[15];
  assign ula_rw = ovr | cpu_rw;
  assign sram_a = fast_hit ? cpu_address[14:12] : 3'b000;
  assign sram_ce_n = 1'b0;
  assign sram_oe_n = !(fast_hit & cpu_rw & cpu_clk_in);
  assign sram_we_n = !(fast_hit & !cpu_rw & cpu_clk_in);
  assign cpu_data = (cpu_clk_in & ctrl_rd) ? status :
                    (cpu_clk_in & cpu_rw & !fast_hit) ? ula_data : 8'bz;
  assign ula_data = (cpu_clk_in & !cpu_rw & !fast_hit) ? cpu_data : 8'bz;
endmodule

// File: tb/tb_ostc_turbo_ctrl.sv
// tb_ostc_turbo_ctrl: directed scoreboard bench for ostc_turbo_ctrl (default and FAST_PAGES=8 instances)
module tb_ostc_turbo_ctrl;
  localparam int TA = 0, A15 = 1, A14 = 2, RW = 3, SA = 4, OE = 5, WE = 6, CE = 7;
  localparam int CD = 8, UD = 9, SA8 = 10, A158 = 11, A148 = 12;
  typedef struct {
    string name;
    int sel;
    logic [7:0] exp;
  } chk_t;
  chk_t qhi[$];
  chk_t qlo[$];
  int vectors = 0;
  int errs = 0;
  logic clk = 1'b0;
  logic rst_n, rw, sw, cpu_en, ula_en;
  logic [15:0] addr;
  logic [7:0] cpu_drv, ula_drv;
  logic a14, a15, urw, oe_n, we_n, ce_n, ta;
  logic [2:0] sa;
  logic a14_8, a15_8, urw_8, oe_n8, we_n8, ce_n8, ta_8;
  logic [2:0] sa_8;
  tri1 [7:0] cpu_data, ula_data, cpu_data8, ula_data8;
  assign cpu_data = cpu_en ? cpu_drv : 8'bz;
  assign ula_data = ula_en ? ula_drv : 8'bz;
  assign cpu_data8 = cpu_en ? cpu_drv : 8'bz;
  assign ula_data8 = ula_en ? ula_drv : 8'bz;
  always #5 clk = ~clk;
  ostc_turbo_ctrl dut (
    .cpu_clk_in(clk), .cpu_rst_n(rst_n), .cpu_address(addr), .cpu_rw(rw),
    .turbo_switch(sw), .ula_a14(a14), .ula_a15(a15), .ula_rw(urw), .sram_a(sa),
    .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_ce_n(ce_n), .cpu_data(cpu_data),
    .ula_data(ula_data), .turbo_active(ta)
  );
  ostc_turbo_ctrl #(.FAST_PAGES(8)) dut8 (
    .cpu_clk_in(clk), .cpu_rst_n(rst_n), .cpu_address(addr), .cpu_rw(rw),
    .turbo_switch(sw), .ula_a14(a14_8), .ula_a15(a15_8), .ula_rw(urw_8), .sram_a(sa_8),
    .sram_oe_n(oe_n8), .sram_we_n(we_n8), .sram_ce_n(ce_n8), .cpu_data(cpu_data8),
    .ula_data(ula_data8), .turbo_active(ta_8)
  );
  function automatic logic [7:0] actual(input int s);
    case (s)
      TA:   return {7'b0, ta};
      A15:  return {7'b0, a15};
      A14:  return {7'b0, a14};
      RW:   return {7'b0, urw};
      SA:   return {5'b0, sa};
      OE:   return {7'b0, oe_n};
      WE:   return {7'b0, we_n};
      CE:   return {7'b0, ce_n};
      CD:   return cpu_data;
      UD:   return ula_data;
      SA8:  return {5'b0, sa_8};
      A158: return {7'b0, a15_8};
      A148: return {7'b0, a14_8};
      default: return 8'h00;
    endcase
  endfunction
  task automatic cmp(input chk_t c);
    logic [7:0] got;
    got = actual(c.sel);
    vectors++;
    if (got !== c.exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", c.name, got, c.exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    while (qhi.size() > 0) cmp(qhi.pop_front());
  end
  initial forever begin
    @(negedge clk);
    #3;
    while (qlo.size() > 0) cmp(qlo.pop_front());
  end
  task automatic chk(input string n, input int s, input logic [7:0] e);
    qhi.push_back('{n, s, e});
  endtask
  task automatic chklo(input string n, input int s, input logic [7:0] e);
    qlo.push_back('{n, s, e});
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic drive(input logic [15:0] a, input logic r, input logic ue, input logic [7:0] ud,
                       input logic ce, input logic [7:0] cd);
    addr = a;
    rw = r;
    ula_en = ue;
    ula_drv = ud;
    cpu_en = ce;
    cpu_drv = cd;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    sw = 1'b0;
    drive(16'h4000, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00);
    chk("rst_ta", TA, 8'h00); chk("rst_a15", A15, 8'h00); chk("rst_a14", A14, 8'h01);
    chk("rst_rw", RW, 8'h01); chk("rst_sa", SA, 8'h00); chk("rst_oe", OE, 8'h01);
    chk("rst_we", WE, 8'h01); chk("rst_ce", CE, 8'h00); chk("rst_cd", CD, 8'h3C);
    tick(2);
    rst_n = 1'b1;
    chklo("lo_cd_z", CD, 8'hFF);
    sw = 1'b1;
    tick(10);
    sw = 1'b0;
    tick(20);
    chk("pulse_ta", TA, 8'h00);
    drive(16'hC000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    sw = 1'b1;
    tick(17);
    chk("arm_fast_ta", TA, 8'h00);
    tick(1);
    chk("fast_ta", TA, 8'h01);
    drive(16'h1000, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00);
    chk("frd_a15", A15, 8'h01); chk("frd_a14", A14, 8'h01); chk("frd_rw", RW, 8'h01);
    chk("frd_sa", SA, 8'h01); chk("frd_oe", OE, 8'h00); chk("frd_we", WE, 8'h01);
    chk("frd_cd_z", CD, 8'hFF);
    chklo("lo_oe", OE, 8'h01);
    tick(1);
    drive(16'h1000, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5);
    chk("fwr_we", WE, 8'h00); chk("fwr_oe", OE, 8'h01); chk("fwr_rw", RW, 8'h01);
    chk("fwr_ud_z", UD, 8'hFF);
    tick(1);
    drive(16'h4000, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5);
    chk("swr_rw", RW, 8'h00); chk("swr_ud", UD, 8'hA5); chk("swr_a15", A15, 8'h00);
    chk("swr_sa", SA, 8'h00); chk("swr_we", WE, 8'h01);
    chklo("lo_ud_z", UD, 8'hFF);
    tick(1);
    drive(16'h4000, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00);
    chk("srd_cd", CD, 8'h3C);
    chklo("lo_srd_cd_z", CD, 8'hFF);
    tick(1);
    drive(16'h1000, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00);
    sw = 1'b0;
    tick(20);
    chk("armslow_ta", TA, 8'h01); chk("armslow_a15", A15, 8'h01);
    tick(5);
    chk("armslow_hold_ta", TA, 8'h01); chk("armslow_hold_a15", A15, 8'h01);
    drive(16'hC000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    tick(1);
    drive(16'h1000, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00);
    chk("slow_ta", TA, 8'h00); chk("slow_a15", A15, 8'h00); chk("slow_a14", A14, 8'h00);
    chk("slow_sa", SA, 8'h01); chk("slow_oe", OE, 8'h00); chk("slow_cd_z", CD, 8'hFF);
    tick(1);
    drive(16'hC000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    sw = 1'b1;
    tick(18);
    chk("win_ta", TA, 8'h01);
    drive(16'h7FFF, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("win8_sa", SA8, 8'h07); chk("win8_a15", A158, 8'h01); chk("win8_a14", A148, 8'h01);
    chk("win3_sa", SA, 8'h00); chk("win3_a15", A15, 8'h00);
    tick(1);
    drive(16'h8000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("out8_sa", SA8, 8'h00); chk("out8_a15", A158, 8'h01); chk("out8_a14", A148, 8'h00);
    tick(1);
    drive(16'hC000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    sw = 1'b0;
    tick(18);
    chk("back_slow_ta", TA, 8'h00);
`ifdef OSTC_CTRL_REG_EN
    drive(16'hFCF0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03);
    chk("ctrl_fwd_ud", UD, 8'h03); chk("ctrl_fwd_rw", RW, 8'h00);
    tick(1);
    drive(16'hFCF0, 1'b0 ^ 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("ctrl_rd_prewrite", CD, 8'h03);
    tick(1);
    chk("ctrl_rd_arm", CD, 8'h43);
    tick(1);
    chk("ctrl_rd_fast", CD, 8'h83); chk("ctrl_rd_ud_z", UD, 8'hFF); chk("ctrl_ta", TA, 8'h01);
    drive(16'hFCF0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02);
    tick(1);
    drive(16'hC000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    tick(2);
    chk("lock_off_ta", TA, 8'h00);
    drive(16'hFCF0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("lock_off_rd", CD, 8'h02);
    tick(1);
    drive(16'hFCF0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01);
    tick(1);
`else
    drive(16'hFCF0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03);
    chk("noctrl_fwd_ud", UD, 8'h03);
    tick(1);
    drive(16'hFCF0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("noctrl_rd_z", CD, 8'hFF);
    tick(3);
    chk("noctrl_ta", TA, 8'h00);
    drive(16'hFCF0, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00);
    chk("noctrl_rd_ula", CD, 8'h5A);
    tick(1);
`endif
    drive(16'hC000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    sw = 1'b1;
    tick(17);
`ifdef OSTC_CTRL_REG_EN
    drive(16'hFCF0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("pre_rst_arm", CD, 8'h41);
`endif
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("post_rst_ta", TA, 8'h00);
    tick(1);
    chk("post_rst_ta2", TA, 8'h00);
    drive(16'hFCF0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
`ifdef OSTC_CTRL_REG_EN
    chk("post_rst_ctrl", CD, 8'h00);
`else
    chk("post_rst_cd_z", CD, 8'hFF);
`endif
    tick(2);
    if (qhi.size() + qlo.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d checks pending, expected 0", qhi.size() + qlo.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
